// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   boot_state_e : loader FSM states (StCsum only with BOOT_CHECKSUM_EN)
//   HDR_BYTES    : bytes in the word-count header
//   WORD_BYTES   : bytes per instruction word
// Configuration macro: BOOT_CHECKSUM_EN adds the trailing checksum state.
package boot_pkg;

   localparam int unsigned HDR_BYTES  = 2;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      StHdrHi,
      StHdrLo,
      StData,
`ifdef BOOT_CHECKSUM_EN
      StCsum,
`endif
      StFlush,
      StDone,
      StErr
   } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears counter and registers)
//   byte_en     : accept byte_in this cycle
//   byte_in     : incoming byte, MSB of the word first
//   last_byte   : combinational, the next accepted byte completes a word
//   word        : last completed word (held until the next word completes)
//   word_valid  : one-cycle pulse in the cycle after a word completes
module boot_word_packer
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        last_byte,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt_q;
   logic [23:0] shift_q;
   logic [31:0] word_q;
   logic        valid_q;

   assign last_byte  = (cnt_q == 2'(WORD_BYTES - 1));
   assign word       = word_q;
   assign word_valid = valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= byte_en && last_byte;
         if (byte_en) begin
            // Counter wraps 3 -> 0 so the next word starts cleanly.
            cnt_q   <= cnt_q + 1'b1;
            shift_q <= {shift_q[15:0], byte_in};
            if (last_byte) begin
               word_q <= {shift_q, byte_in};
            end
         end
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a program image as a byte stream (16-bit word count N,
// then N big-endian words), writes the words to instruction memory from address 0,
// then releases the core's active-low reset.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : one-cycle instruction-memory write
//   core_rstb             : active-low core reset, high once boot completes
//   boot_done, boot_err   : sticky status flags
// Configuration macro: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rstb,
   output logic              boot_done,
   output logic              boot_err
);

   localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

   boot_state_e       state_q, state_d;
   logic [7:0]        hdr_hi_q;
   logic [ADDR_W:0]   n_q;      // one extra bit so N == 2^ADDR_W fits
   logic [ADDR_W:0]   idx_q;
   logic [ADDR_W:0]   idx_inc;
   logic [ADDR_W-1:0] addr_q;
   logic              rx_ready_q, core_rstb_q, boot_done_q, boot_err_q;
   logic              rx_ready_d;
   logic              accept, data_acc, last_byte;
   logic [15:0]       hdr_n;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   assign accept   = rx_valid && rx_ready_q;
   assign data_acc = accept && (state_q == StData);
   assign hdr_n    = {hdr_hi_q, rx_data};
   assign idx_inc  = idx_q + 1'b1;

   boot_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .byte_en    (data_acc),
      .byte_in    (rx_data),
      .last_byte  (last_byte),
      .word       (imem_wdata),
      .word_valid (imem_we)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StHdrHi: if (accept) state_d = StHdrLo;
         StHdrLo: begin
            if (accept) begin
               if (hdr_n == 16'd0 || {1'b0, hdr_n} > MaxWords) state_d = StErr;
               else                                            state_d = StData;
            end
         end
         StData: begin
            // Leave on the byte completing the final word; its write lands in the next state.
            if (data_acc && last_byte && idx_inc == n_q) begin
`ifdef BOOT_CHECKSUM_EN
               state_d = StCsum;
`else
               state_d = StFlush;
`endif
            end
         end
`ifdef BOOT_CHECKSUM_EN
         StCsum: begin
            if (accept) state_d = (rx_data == csum_q) ? StFlush : StErr;
         end
`endif
         StFlush: state_d = StDone;
         StDone:  state_d = StDone;
         StErr:   state_d = StErr;
         default: state_d = StHdrHi;
      endcase

      rx_ready_d = (state_d == StHdrHi) || (state_d == StHdrLo) || (state_d == StData)
`ifdef BOOT_CHECKSUM_EN
                   || (state_d == StCsum)
`endif
                   ;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StHdrHi;
         hdr_hi_q    <= '0;
         n_q         <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         rx_ready_q  <= 1'b0;
         core_rstb_q <= 1'b0;
         boot_done_q <= 1'b0;
         boot_err_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready_d;
         // Flags follow the next state so they rise on the transition edge.
         core_rstb_q <= (state_d == StDone);
         boot_done_q <= (state_d == StDone);
         boot_err_q  <= (state_d == StErr);
         if (accept && state_q == StHdrHi) hdr_hi_q <= rx_data;
         if (accept && state_q == StHdrLo) n_q <= hdr_n[ADDR_W:0];
         if (data_acc && last_byte) begin
            addr_q <= idx_q[ADDR_W-1:0];
            idx_q  <= idx_inc;
         end
`ifdef BOOT_CHECKSUM_EN
         if (data_acc) csum_q <= csum_q ^ rx_data;
`endif
      end
   end

   assign rx_ready  = rx_ready_q;
   assign imem_addr = addr_q;
   assign core_rstb = core_rstb_q;
   assign boot_done = boot_done_q;
   assign boot_err  = boot_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random images with a scoreboard of
// expected memory writes, header/checksum error cases, mid-load reset and a full
// 1024-word image.
module tb_imem_boot_loader;

   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rstb;
   logic              boot_done;
   logic              boot_err;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t         exp_q[$];
   int unsigned img_words[$];
   int          errors = 0;
   int          checks = 0;
   bit          use_gaps = 1'b0;

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rstb  (core_rstb),
      .boot_done  (boot_done),
      .boot_err   (boot_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every write must match the head of the expected queue.
   initial begin : monitor
      wr_t e;
      forever begin
         @(negedge clk);
         if (imem_we) begin
            chk(!core_rstb, "core_rstb_during_write", longint'(core_rstb), 0);
            chk(exp_q.size() != 0, "unexpected_write", longint'(imem_addr), 0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk(imem_addr == e.addr, "write_addr", longint'(imem_addr), longint'(e.addr));
               chk(imem_wdata == e.data, "write_data", longint'(imem_wdata), longint'(e.data));
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   function automatic int gap_of();
      return use_gaps ? int'($urandom_range(3, 0)) : 0;
   endfunction

   task automatic do_reset();
      rx_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk({rx_ready, imem_we, imem_addr, imem_wdata, core_rstb, boot_done, boot_err} == '0,
          "reset_outputs",
          longint'({rx_ready, imem_we, imem_addr, imem_wdata, core_rstb, boot_done, boot_err}), 0);
      rst = 1'b0;
      @(negedge clk);
      chk(rx_ready == 1'b1, "rx_ready_after_reset", longint'(rx_ready), 1);
   endtask

   // Presents one byte and returns at the falling edge after it was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) begin
         chk(1'b0, "rx_ready_timeout", 0, 1);
         rx_valid = 1'b0;
         return;
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic run_image(input logic [15:0] n, input bit bad_csum);
      bit          hdr_bad;
      bit          exp_err;
      logic [7:0]  x = '0;
      logic [7:0]  b;
      logic [31:0] w;
      wr_t         e;
      hdr_bad = (n == 16'd0) || (int'(n) > (1 << ADDR_W));
      do_reset();
      if (!hdr_bad) begin
         for (int i = 0; i < int'(n); i++) begin
            e.addr = ADDR_W'(i);
            e.data = img_words[i];
            exp_q.push_back(e);
         end
      end
      send_byte(n[15:8], gap_of());
      send_byte(n[7:0], gap_of());
      if (hdr_bad) begin
         chk(boot_err == 1'b1, "hdr_err_flag", longint'(boot_err), 1);
         chk(rx_ready == 1'b0, "hdr_err_rx_ready", longint'(rx_ready), 0);
         repeat (3) @(negedge clk);
         chk({boot_err, core_rstb, boot_done} == 3'b100, "hdr_err_sticky",
             longint'({boot_err, core_rstb, boot_done}), 4);
         return;
      end
      for (int i = 0; i < int'(n); i++) begin
         w = img_words[i];
         for (int k = 3; k >= 0; k--) begin
            b = w[8*k +: 8];
            x ^= b;
            send_byte(b, gap_of());
         end
      end
      exp_err = 1'b0;
`ifdef BOOT_CHECKSUM_EN
      exp_err = bad_csum;
      send_byte(bad_csum ? (x ^ 8'h01) : x, gap_of());
`endif
      chk(core_rstb == 1'b0, "core_rstb_in_flush", longint'(core_rstb), 0);
      @(negedge clk);
      chk(core_rstb == !exp_err, "core_rstb_final", longint'(core_rstb), longint'(!exp_err));
      chk(boot_done == !exp_err, "boot_done_final", longint'(boot_done), longint'(!exp_err));
      chk(boot_err == exp_err, "boot_err_final", longint'(boot_err), longint'(exp_err));
      repeat (2) @(negedge clk);
      chk(exp_q.size() == 0, "writes_missing", longint'(exp_q.size()), 0);
   endtask

   task automatic random_words(input int n);
      img_words.delete();
      for (int i = 0; i < n; i++) img_words.push_back($urandom);
   endtask

   initial begin : stim
      wr_t e;
      logic [31:0] w0;
      // Reference image from the test plan, back-to-back then with gaps.
      img_words = '{32'h2008_0005, 32'h2009_000A};
      use_gaps = 1'b0;
      run_image(16'd2, 1'b0);
`ifdef BOOT_CHECKSUM_EN
      run_image(16'd2, 1'b1);
`endif
      use_gaps = 1'b1;
      run_image(16'd2, 1'b0);

      // Bytes offered after completion are ignored.
      rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rx_data = 8'($urandom);
         @(negedge clk);
         chk({rx_ready, boot_done, core_rstb} == 3'b011, "done_ignores_bytes",
             longint'({rx_ready, boot_done, core_rstb}), 3);
      end
      rx_valid = 1'b0;

      // Bad headers.
      run_image(16'h0000, 1'b0);
      run_image(16'h0401, 1'b0);

      // Reset after 5 payload bytes: only word 0 is written, then a clean reload.
      random_words(3);
      do_reset();
      w0 = img_words[0];
      e.addr = '0;
      e.data = w0;
      exp_q.push_back(e);
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      for (int k = 3; k >= 0; k--) send_byte(w0[8*k +: 8], 0);
      send_byte(8'hA5, 0);
      @(negedge clk);
      chk(exp_q.size() == 0, "partial_write", longint'(exp_q.size()), 0);
      run_image(16'd3, 1'b0);

      // Randomised images.
      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(8, 1));
         random_words(n);
         use_gaps = 1'($urandom_range(1, 0));
         run_image(16'(n), 1'b0);
      end

      // Full-size image: last write at 1023, no wrap.
      use_gaps = 1'b0;
      random_words(1 << ADDR_W);
      run_image(16'(1 << ADDR_W), 1'b0);

      repeat (3) @(negedge clk);
      chk(exp_q.size() == 0, "scoreboard_empty", longint'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
